// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and constants for the RiSC-16 register-file port controller.
package rf_ctrl_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 3'b000;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } rf_state_e;

endpackage

// File: rtl/rf_bypass_sel.sv
// rf_bypass_sel: per-operand bypass. Replaces the register-file read value with the
// same-transaction write data when the write targets this operand's register
// (never for r0, which always reads zero).
module rf_bypass_sel
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] tgt_addr,
  input  logic [DATA_W-1:0] tgt_data,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] rsp_data
);

  logic hit;

  assign hit      = wr_en && (tgt_addr != ADDR_W'(RF_ZERO_REG)) && (tgt_addr == src_addr);
  assign rsp_data = hit ? tgt_data : rf_data;

endmodule

// File: rtl/rf_port_ctrl.sv
// rf_port_ctrl: initiator-side sequencer for the RiSC-16 register file's synchronous port.
// One request (two reads plus an optional write) is captured, issued to the register file
// for one cycle, and the two operands are returned over a valid/ready response channel.
// Build option: define RF_BYPASS_EN to forward same-transaction write data into the
// response (post-write view); without it the response carries pre-write values.
module rf_port_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk0,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src1_addr,
  input  logic [ADDR_W-1:0] req_src2_addr,
  input  logic              req_wr_en,
  input  logic [ADDR_W-1:0] req_tgt_addr,
  input  logic [DATA_W-1:0] req_tgt_data,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_src1_data,
  output logic [DATA_W-1:0] rsp_src2_data,
  // register-file port
  output logic              rf_csb0,
  output logic              rf_werf,
  output logic [ADDR_W-1:0] rf_src1_addr,
  output logic [ADDR_W-1:0] rf_src2_addr,
  output logic [ADDR_W-1:0] rf_tgt_addr,
  output logic [DATA_W-1:0] rf_tgt_data,
  input  logic [DATA_W-1:0] rf_src1_data,
  input  logic [DATA_W-1:0] rf_src2_data
);

  rf_state_e         state;
  rf_state_e         state_next;
  logic              req_fire;

  logic              wr_en_q;
  logic [ADDR_W-1:0] src1_q;
  logic [ADDR_W-1:0] src2_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [DATA_W-1:0] tgt_data_q;

  // State register: synchronous reset drops any in-flight transaction.
  always_ff @(posedge clk0) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/strobe decode; reset forces the strobes inactive at once.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rf_csb0    = 1'b1;
    rf_werf    = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        rf_csb0    = 1'b0;
        rf_werf    = !wr_en_q;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          req_ready  = 1'b1;
          state_next = req_valid ? ISSUE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rf_csb0   = 1'b1;
      rf_werf   = 1'b1;
    end
  end

  assign req_fire = req_valid && req_ready;

  // Holding registers: capture the request fields on accept.
  always_ff @(posedge clk0) begin
    // NOTE: holding registers are cleared on reset so the register-file pins come up defined.
    if (rst) begin
      wr_en_q    <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      tgt_q      <= '0;
      tgt_data_q <= '0;
    end else if (req_fire) begin
      wr_en_q    <= req_wr_en;
      src1_q     <= req_src1_addr;
      src2_q     <= req_src2_addr;
      tgt_q      <= req_tgt_addr;
      tgt_data_q <= req_tgt_data;
    end
  end

  assign rf_src1_addr = src1_q;
  assign rf_src2_addr = src2_q;
  assign rf_tgt_addr  = tgt_q;
  assign rf_tgt_data  = tgt_data_q;

`ifdef RF_BYPASS_EN
  rf_bypass_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_src1 (
    .wr_en    (wr_en_q),
    .tgt_addr (tgt_q),
    .tgt_data (tgt_data_q),
    .src_addr (src1_q),
    .rf_data  (rf_src1_data),
    .rsp_data (rsp_src1_data)
  );

  rf_bypass_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_src2 (
    .wr_en    (wr_en_q),
    .tgt_addr (tgt_q),
    .tgt_data (tgt_data_q),
    .src_addr (src2_q),
    .rf_data  (rf_src2_data),
    .rsp_data (rsp_src2_data)
  );
`else
  assign rsp_src1_data = rf_src1_data;
  assign rsp_src2_data = rf_src2_data;
`endif

endmodule

// File: tb/tb_rf_port_ctrl.sv
// tb_rf_port_ctrl: self-checking bench for rf_port_ctrl. A behavioural register file sits
// on the rf_* port; an architectural register array predicts every response.
module tb_rf_port_ctrl;

  logic        clk0 = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_src1_addr, req_src2_addr, req_tgt_addr;
  logic        req_wr_en;
  logic [15:0] req_tgt_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_src1_data, rsp_src2_data;
  logic        rf_csb0, rf_werf;
  logic [2:0]  rf_src1_addr, rf_src2_addr, rf_tgt_addr;
  logic [15:0] rf_tgt_data;
  logic [15:0] rf_src1_data, rf_src2_data;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk0 = ~clk0;

  rf_port_ctrl dut (
    .clk0          (clk0),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_src1_addr (req_src1_addr),
    .req_src2_addr (req_src2_addr),
    .req_wr_en     (req_wr_en),
    .req_tgt_addr  (req_tgt_addr),
    .req_tgt_data  (req_tgt_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_src1_data (rsp_src1_data),
    .rsp_src2_data (rsp_src2_data),
    .rf_csb0       (rf_csb0),
    .rf_werf       (rf_werf),
    .rf_src1_addr  (rf_src1_addr),
    .rf_src2_addr  (rf_src2_addr),
    .rf_tgt_addr   (rf_tgt_addr),
    .rf_tgt_data   (rf_tgt_data),
    .rf_src1_data  (rf_src1_data),
    .rf_src2_data  (rf_src2_data)
  );

  // Behavioural register file: synchronous, read returns pre-write value, r0 reads zero.
  logic [15:0] rf_mem [8];
  int          wr_strobes   = 0;
  logic [2:0]  last_wr_addr = '0;

  initial begin
    foreach (rf_mem[i]) rf_mem[i] = '0;
    rf_src1_data = '0;
    rf_src2_data = '0;
  end

  always @(posedge clk0) begin
    if (!rf_csb0) begin
      rf_src1_data <= (rf_src1_addr == 3'd0) ? 16'h0 : rf_mem[rf_src1_addr];
      rf_src2_data <= (rf_src2_addr == 3'd0) ? 16'h0 : rf_mem[rf_src2_addr];
      if (!rf_werf) begin
        rf_mem[rf_tgt_addr] <= rf_tgt_data;
        wr_strobes          <= wr_strobes + 1;
        last_wr_addr        <= rf_tgt_addr;
      end
    end
  end

  // Architectural reference: register contents after every completed transaction.
  logic [15:0] ref_regs [8];

  function automatic logic [15:0] model_src(input logic [2:0] src, input logic wr,
                                            input logic [2:0] tgt, input logic [15:0] data);
    if (src == 3'd0) return 16'h0;
`ifdef RF_BYPASS_EN
    if (wr && tgt == src) return data;
`endif
    return ref_regs[src];
  endfunction

  function automatic void model_commit(input logic wr, input logic [2:0] tgt, input logic [15:0] data);
    if (wr) ref_regs[tgt] = data;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] s1, input logic [2:0] s2, input logic wr,
                           input logic [2:0] tgt, input logic [15:0] data);
    req_valid     = 1'b1;
    req_src1_addr = s1;
    req_src2_addr = s2;
    req_wr_en     = wr;
    req_tgt_addr  = tgt;
    req_tgt_data  = data;
  endtask

  // One isolated transaction: accept, ISSUE, RESP two cycles after accept, then drain.
  task automatic run_txn(input string tag, input logic [2:0] s1, input logic [2:0] s2,
                         input logic wr, input logic [2:0] tgt, input logic [15:0] data);
    logic [15:0] e1, e2;
    int waited;
    e1 = model_src(s1, wr, tgt, data);
    e2 = model_src(s2, wr, tgt, data);
    @(negedge clk0);
    drive_req(s1, s2, wr, tgt, data);
    rsp_ready = 1'b0;
    #1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk0);
      #1;
      waited++;
    end
    check({tag, "_accept_in_time"}, 32'(waited < 20), 32'd1);
    @(negedge clk0);
    req_valid = 1'b0;
    check({tag, "_issue_rsp_valid"}, rsp_valid, 1'b0);
    @(negedge clk0);
    check({tag, "_resp_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_src1"}, rsp_src1_data, e1);
    check({tag, "_src2"}, rsp_src2_data, e2);
    rsp_ready = 1'b1;
    @(negedge clk0);
    rsp_ready = 1'b0;
    model_commit(wr, tgt, data);
    check({tag, "_drain_rsp_valid"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  b_s1 [11];
    logic [2:0]  b_s2 [11];
    logic        b_wr [11];
    logic [2:0]  b_tg [11];
    logic [15:0] b_dt [11];
    logic [15:0] e1, e2, ea1, ea2;
    logic [15:0] rnd;
    int          strobes_before;

    foreach (ref_regs[i]) ref_regs[i] = '0;
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    drive_req(3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    req_valid = 1'b0;

    // Reset state.
    @(negedge clk0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_csb0", rf_csb0, 1'b1);
    check("rst_werf", rf_werf, 1'b1);
    @(negedge clk0);
    check("rst_hold_addr", rf_tgt_addr, 3'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", req_ready, 1'b1);

    // Write r3, then read r3 and r0.
    run_txn("wr_r3", 3'd0, 3'd0, 1'b1, 3'd3, 16'hBEEF);
    run_txn("rd_r3", 3'd3, 3'd0, 1'b0, 3'd0, 16'h0);
    check("rd_r3_const", rsp_src1_data, 16'hBEEF);

    // Write to r0 is issued but r0 still reads zero.
    strobes_before = wr_strobes;
    run_txn("wr_r0", 3'd0, 3'd0, 1'b1, 3'd0, 16'h1234);
    check("wr_r0_strobe", 32'(wr_strobes - strobes_before), 32'd1);
    check("wr_r0_addr", last_wr_addr, 3'd0);
    run_txn("rd_r0", 3'd0, 3'd3, 1'b0, 3'd0, 16'h0);

    // Same-address write and read in one transaction.
    run_txn("pre_r5", 3'd0, 3'd0, 1'b1, 3'd5, 16'h1111);
    run_txn("wr_rd_r5", 3'd5, 3'd5, 1'b1, 3'd5, 16'hA5A5);
    run_txn("rd_r5", 3'd5, 3'd0, 1'b0, 3'd0, 16'h0);

    // Response back-pressure with a pending request, then same-cycle hand-over.
    ea1 = model_src(3'd3, 1'b0, 3'd0, 16'h0);
    ea2 = model_src(3'd5, 1'b0, 3'd0, 16'h0);
    @(negedge clk0);
    drive_req(3'd3, 3'd5, 1'b0, 3'd0, 16'h0);
    rsp_ready = 1'b0;
    @(negedge clk0);
    drive_req(3'd6, 3'd3, 1'b1, 3'd6, 16'h5A5A);
    check("stall_issue_req_ready", req_ready, 1'b0);
    @(negedge clk0);
    for (int k = 0; k < 4; k++) begin
      check("stall_rsp_valid", rsp_valid, 1'b1);
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_src1", rsp_src1_data, ea1);
      check("stall_src2", rsp_src2_data, ea2);
      @(negedge clk0);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_req_ready", req_ready, 1'b1);
    check("release_rsp_valid", rsp_valid, 1'b1);
    model_commit(1'b0, 3'd0, 16'h0);
    e1 = model_src(3'd6, 1'b1, 3'd6, 16'h5A5A);
    e2 = model_src(3'd3, 1'b1, 3'd6, 16'h5A5A);
    @(negedge clk0);
    req_valid = 1'b0;
    check("release_issue_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk0);
    check("release_resp_rsp_valid", rsp_valid, 1'b1);
    check("release_src1", rsp_src1_data, e1);
    check("release_src2", rsp_src2_data, e2);
    @(negedge clk0);
    rsp_ready = 1'b0;
    model_commit(1'b1, 3'd6, 16'h5A5A);

    // Reset during ISSUE of a write: no strobe, no response, old value kept.
    run_txn("pre_r2", 3'd0, 3'd0, 1'b1, 3'd2, 16'h0042);
    @(negedge clk0);
    drive_req(3'd2, 3'd2, 1'b1, 3'd2, 16'hFFFF);
    @(negedge clk0);
    req_valid = 1'b0;
    check("rstmid_issue_csb0", rf_csb0, 1'b0);
    strobes_before = wr_strobes;
    rst = 1'b1;
    #1;
    check("rstmid_csb0", rf_csb0, 1'b1);
    check("rstmid_werf", rf_werf, 1'b1);
    check("rstmid_req_ready", req_ready, 1'b0);
    @(negedge clk0);
    check("rstmid_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk0);
      check("rstmid_no_rsp", rsp_valid, 1'b0);
    end
    check("rstmid_no_write", 32'(wr_strobes - strobes_before), 32'd0);
    run_txn("rd_r2", 3'd2, 3'd0, 1'b0, 3'd0, 16'h0);
    check("rd_r2_const", rsp_src1_data, 16'h0042);

    // Random isolated transactions.
    for (int t = 0; t < 12; t++) begin
      rnd = 16'($urandom);
      run_txn("rand", 3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
              3'($urandom_range(7)), rnd);
    end

    // Ten back-to-back random requests with rsp_ready tied high.
    for (int i = 0; i < 10; i++) begin
      b_s1[i] = 3'($urandom_range(7));
      b_s2[i] = 3'($urandom_range(7));
      b_wr[i] = 1'($urandom_range(1));
      b_tg[i] = (i % 3 == 0) ? b_s1[i] : 3'($urandom_range(7));
      b_dt[i] = 16'($urandom);
    end
    @(negedge clk0);
    rsp_ready = 1'b1;
    drive_req(b_s1[0], b_s2[0], b_wr[0], b_tg[0], b_dt[0]);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("b2b_req_ready", req_ready, 1'b1);
      e1 = model_src(b_s1[i], b_wr[i], b_tg[i], b_dt[i]);
      e2 = model_src(b_s2[i], b_wr[i], b_tg[i], b_dt[i]);
      model_commit(b_wr[i], b_tg[i], b_dt[i]);
      @(negedge clk0);
      check("b2b_issue_rsp_valid", rsp_valid, 1'b0);
      if (i < 9) drive_req(b_s1[i+1], b_s2[i+1], b_wr[i+1], b_tg[i+1], b_dt[i+1]);
      else       req_valid = 1'b0;
      @(negedge clk0);
      check("b2b_rsp_valid", rsp_valid, 1'b1);
      check("b2b_src1", rsp_src1_data, e1);
      check("b2b_src2", rsp_src2_data, e2);
    end
    @(negedge clk0);
    rsp_ready = 1'b0;
    check("b2b_end_idle", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rf_port_ctrl.md
# rf_port_ctrl

Initiator-side controller that drives the RiSC-16 register file's synchronous port: `csb0`/`werf` active-low strobes, three addresses, 16-bit write data and one-cycle registered read data. It accepts one combined read/write request per transaction from the pipeline over a valid/ready handshake and sequences the register-file strobes. It returns both source operands over a second valid/ready handshake, and optionally forwards same-transaction write data.

## Interface
- `DATA_W`, 16, register width
- `ADDR_W`, 3, register address width (8 registers, r0 reads zero)
- `clk0`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request offered
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a rising edge
- `req_src1_addr`, `req_src2_addr`  in  ADDR_W  operand addresses
- `req_wr_en`  in  1  request also writes `req_tgt_data` to `req_tgt_addr`
- `req_tgt_addr`  in  ADDR_W; `req_tgt_data`  in  DATA_W
- `rsp_valid`  out  1; `rsp_ready`  in  1  response handshake
- `rsp_src1_data`, `rsp_src2_data`  out  DATA_W  operand values
- `rf_csb0`, `rf_werf`  out  1  register-file chip select / write enable, active-low
- `rf_src1_addr`, `rf_src2_addr`, `rf_tgt_addr`  out  ADDR_W; `rf_tgt_data`  out  DATA_W
- `rf_src1_data`, `rf_src2_data`  in  DATA_W  register-file read outputs

## Operation
- States: IDLE, ISSUE, RESP. Reset value is IDLE.
- Accept: the request fields are captured into the address/data/wr_en holding registers.
- IDLE: `req_ready`=1. On accept → ISSUE.
- ISSUE: `rf_csb0`=0. `rf_werf`=!wr_en. The rf_* addresses and data come from the holding registers. At the edge the register file writes (if enabled) and reads both sources → RESP.
- RESP: `rsp_valid`=1 and `rf_csb0`=1, so the register file holds its outputs. `rsp_*_data` come from `rf_src*_data`, through the bypass mux when it is configured.
- RESP with `rsp_ready`=0: stay in RESP. Data and `rsp_valid` stay stable.
- RESP with `rsp_ready`=1 and `req_valid`=0: → IDLE.
- RESP with `rsp_ready`=1 and `req_valid`=1: `req_ready`=1 and the new request is accepted → ISSUE. This gives back-to-back operation.
- `req_ready` = (state==IDLE) || (state==RESP && rsp_ready). It is combinational from state and `rsp_ready`.
- `req_ready` is 0 in ISSUE.
- Writes to r0 are issued to the register file. Reads of r0 return 0, and the bypass never forwards r0.
- The register file reads the pre-write value when the write and read hit the same address in one cycle.

## Timing
- Latency: accept at edge N → ISSUE during cycle N+1 → `rsp_valid` high from cycle N+2.
- Minimum period is 2 cycles per transaction when back-to-back.
- Reset values: `req_ready`=0 during the reset cycle, then 1 in IDLE.
- Reset values: `rsp_valid`=0, `rf_csb0`=1, `rf_werf`=1. Holding registers clear to 0.
- `rf_csb0` and `rf_werf` are forced high combinationally while `rst`=1. An op in ISSUE when reset asserts never writes.
- Reset mid-operation: any in-flight request or response is dropped with no response.
- `rsp_*_data` are don't-care when `rsp_valid`=0.

## Configuration
- `RF_BYPASS_EN` defined: in RESP, if the registered wr_en=1 and tgt_addr≠0 and tgt_addr==srcX_addr, then `rsp_srcX_data` = registered tgt_data. This is evaluated independently for src1 and src2. The response therefore reflects post-write state.
- `RF_BYPASS_EN` undefined: `rsp_srcX_data` = `rf_srcX_data` unconditionally, which returns pre-write values. No bypass logic is present.

## Structure
- Shared package `rf_ctrl_pkg` holds:
  - state enum (IDLE/ISSUE/RESP)
  - `RF_DATA_W`=16 and `RF_ADDR_W`=3
  - `RF_ZERO_REG`=3'b000
- One sub-module, `rf_bypass_sel`, handles one operand: compare and mux. It is instantiated twice and only when `RF_BYPASS_EN` is defined.

## Test plan
- Write r3=0xBEEF, then read src1=r3, src2=r0 → response 0xBEEF, 0x0000. `rsp_valid` is first seen 2 cycles after each accept.
- Write r0=0x1234, then read src1=r0 → 0x0000, in both configurations.
- Preload r5=0x1111, then a single request writing r5=0xA5A5 and reading src1=src2=r5 → 0xA5A5 with `RF_BYPASS_EN`, 0x1111 without. A following read of r5 → 0xA5A5.
- Hold `rsp_ready`=0 for 4 cycles with `req_valid`=1 → `req_ready`=0 and response data stable throughout. Then raise `rsp_ready` → the next request is accepted in the same cycle and its `rsp_valid` appears 2 cycles later.
- Assert `rst` during ISSUE of a write r2=0xFFFF (r2 preloaded 0x0042) → no write strobe, `rsp_valid` stays 0. A subsequent read of r2 → 0x0042.
- Ten back-to-back requests with `rsp_ready` tied 1 → one response every 2 cycles, all data correct.
